// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter: NUM_SRC sources share one master link.
// Define AXIS_ARB_REGOUT_EN to register m_* through a 2-entry FIFO (+1 cycle latency).
module axis_rr_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        s_tvalid,
    input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]        s_tlast,
    output logic [NUM_SRC-1:0]        s_tready,
    output logic                      m_tvalid,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      busy,
    output logic [15:0]               pkt_cnt
);
    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_g;
    logic [IDX_W-1:0]   r_g_last;
    logic [IDX_W-1:0]   w_g_nxt;
    logic [15:0]        r_pkt_cnt;

    logic [IDX_W-1:0]   w_arb_base;
    logic [IDX_W-1:0]   w_arb_idx;
    logic [IDX_W-1:0]   w_scan_idx;
    logic               w_arb_found;

    logic               w_busy;
    logic               w_own_valid;
    logic [DATA_W-1:0]  w_own_data;
    logic               w_own_last;
    logic               w_src_rdy;
    logic               w_hs;
    logic               w_last_hs;

    // In IDLE scan all sources from g_last+1; in XFER scan only the others, starting at g+1.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_scan_idx  = '0;
        w_arb_base  = (r_state == ST_IDLE) ? r_g_last : r_g;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            w_scan_idx = IDX_W'((32'(w_arb_base) + k) % NUM_SRC);
            if (!w_arb_found && (k < NUM_SRC || r_state == ST_IDLE) && s_tvalid[w_scan_idx]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_scan_idx;
            end
        end
    end

    assign w_busy      = (r_state == ST_XFER);
    assign w_own_valid = s_tvalid[r_g];
    assign w_own_data  = s_tdata[32'(r_g)*DATA_W +: DATA_W];
    assign w_own_last  = s_tlast[r_g];
    assign w_hs        = w_busy & w_own_valid & w_src_rdy;
    assign w_last_hs   = w_hs & w_own_last;

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_state_nxt = ST_XFER;
                    w_g_nxt     = w_arb_idx;
                end
            end
            ST_XFER: begin
                if (w_last_hs) begin
                    if (w_arb_found) begin
                        w_g_nxt = w_arb_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_g       <= '0;
            r_g_last  <= IDX_W'(NUM_SRC - 1);
            r_pkt_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
            if (w_last_hs) begin
                r_g_last  <= r_g;
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        grant    = '0;
        s_tready = '0;
        if (w_busy) begin
            grant[r_g]    = 1'b1;
            s_tready[r_g] = w_src_rdy;
        end
    end

    assign busy    = w_busy;
    assign pkt_cnt = r_pkt_cnt;

`ifdef AXIS_ARB_REGOUT_EN
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_last;
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_fifo_cnt;
    logic              w_pop;

    assign w_src_rdy = (r_fifo_cnt < 2'd2);
    assign w_pop     = m_tvalid & m_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_fifo_cnt     <= '0;
        end else begin
            if (w_hs) begin
                r_fifo_data[r_wr_ptr] <= w_own_data;
                r_fifo_last[r_wr_ptr] <= w_own_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_hs, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign m_tvalid = (r_fifo_cnt != 2'd0);
    assign m_tdata  = m_tvalid ? r_fifo_data[r_rd_ptr] : '0;
    assign m_tlast  = m_tvalid & r_fifo_last[r_rd_ptr];
`else
    assign w_src_rdy = m_tready;
    assign m_tvalid  = w_busy & w_own_valid;
    assign m_tdata   = w_busy ? w_own_data : '0;
    assign m_tlast   = w_busy & w_own_last;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (default combinational build, 4 sources).
module tb_axis_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_tvalid;
    logic [31:0] s_tdata;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic        m_tvalid;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [7:0]  d [4];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    assign s_tdata = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    axis_rr_arbiter #(
        .NUM_SRC(4),
        .DATA_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_tvalid(s_tvalid),
        .s_tdata (s_tdata),
        .s_tlast (s_tlast),
        .s_tready(s_tready),
        .m_tvalid(m_tvalid),
        .m_tdata (m_tdata),
        .m_tlast (m_tlast),
        .m_tready(m_tready),
        .grant   (grant),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
        d[0] = '0; d[1] = '0; d[2] = '0; d[3] = '0;
        tick(); tick();
        check("rst_grant",    32'(grant),    'h0);
        check("rst_busy",     32'(busy),     'h0);
        check("rst_m_tvalid", 32'(m_tvalid), 'h0);
        check("rst_m_tdata",  32'(m_tdata),  'h0);
        check("rst_s_tready", 32'(s_tready), 'h0);
        check("rst_pkt_cnt",  32'(pkt_cnt),  'h0);
        rst = 1'b0;

        // single 3-beat packet from source 0
        m_tready = 1'b1; s_tvalid = 4'b0001; d[0] = 8'h11;
        #1 check("s1_req_cycle_grant", 32'(grant), 'h0);
        tick();
        check("s1_grant",    32'(grant),    'h1);
        check("s1_busy",     32'(busy),     'h1);
        check("s1_s_tready", 32'(s_tready), 'h1);
        check("s1_beat0",    32'(m_tdata),  'h11);
        check("s1_valid0",   32'(m_tvalid), 'h1);
        tick(); d[0] = 8'h22;
        #1 check("s1_beat1", 32'(m_tdata), 'h22);
        check("s1_last1",    32'(m_tlast), 'h0);
        tick(); d[0] = 8'h33; s_tlast = 4'b0001;
        #1 check("s1_beat2", 32'(m_tdata), 'h33);
        check("s1_last2",    32'(m_tlast), 'h1);
        tick(); s_tvalid = '0; s_tlast = '0;
        #1 check("s1_pkt_cnt", 32'(pkt_cnt), 'h1);
        check("s1_busy_after",  32'(busy),  'h0);
        check("s1_grant_after", 32'(grant), 'h0);

        // simultaneous 1-beat requests right after reset
        rst = 1'b1;
        tick(); rst = 1'b0;
        s_tvalid = 4'b1111; s_tlast = 4'b1111;
        d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2; d[3] = 8'hA3;
        #1 check("s2_pkt_cnt_reset", 32'(pkt_cnt), 'h0);
        check("s2_req_cycle_grant",   32'(grant),   'h0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("s2_grant_order", 32'(grant),    1 << (k % 4));
            check("s2_data_order",  32'(m_tdata),  'hA0 + (k % 4));
            check("s2_valid",       32'(m_tvalid), 'h1);
            tick();
        end
        s_tvalid = '0; s_tlast = '0;
        #1 check("s2_pkt_cnt", 32'(pkt_cnt), 'h5);
        check("s2_hold_grant", 32'(grant),    'h2);
        check("s2_bubble",     32'(m_tvalid), 'h0);

        // backpressure mid-packet on source 1 (already owner)
        s_tvalid = 4'b0010; d[1] = 8'hB1;
        #1 check("s3_beat0", 32'(m_tdata), 'hB1);
        check("s3_ready0",   32'(s_tready), 'h2);
        tick(); d[1] = 8'hB2; m_tready = 1'b0;
        #1 check("s3_stall_ready", 32'(s_tready), 'h0);
        check("s3_stall_data",     32'(m_tdata),  'hB2);
        check("s3_stall_valid",    32'(m_tvalid), 'h1);
        for (int j = 0; j < 2; j++) begin
            tick();
            check("s3_hold_data",  32'(m_tdata),  'hB2);
            check("s3_hold_ready", 32'(s_tready), 'h0);
            check("s3_hold_cnt",   32'(pkt_cnt),  'h5);
        end
        tick(); m_tready = 1'b1;
        #1 check("s3_resume_ready", 32'(s_tready), 'h2);
        check("s3_resume_data",     32'(m_tdata),  'hB2);
        tick(); d[1] = 8'hB3; s_tlast = 4'b0010;
        #1 check("s3_last_data", 32'(m_tdata), 'hB3);
        check("s3_last_flag",    32'(m_tlast), 'h1);
        tick(); s_tvalid = '0; s_tlast = '0;
        #1 check("s3_pkt_cnt", 32'(pkt_cnt), 'h6);
        check("s3_busy_after", 32'(busy), 'h0);

        // no preemption: source 2 requests during source 1's 4-beat packet
        s_tvalid = 4'b0010; d[1] = 8'hC1;
        #1 check("s4_req_cycle_grant", 32'(grant), 'h0);
        tick();
        check("s4_grant_b1", 32'(grant),   'h2);
        check("s4_data_b1",  32'(m_tdata), 'hC1);
        tick(); d[1] = 8'hC2; s_tvalid = 4'b0110; d[2] = 8'hD1; s_tlast = 4'b0100;
        #1 check("s4_grant_b2", 32'(grant), 'h2);
        check("s4_data_b2",     32'(m_tdata),  'hC2);
        check("s4_ready_b2",    32'(s_tready), 'h2);
        tick(); d[1] = 8'hC3;
        #1 check("s4_grant_b3", 32'(grant), 'h2);
        tick(); d[1] = 8'hC4; s_tlast = 4'b0110;
        #1 check("s4_grant_b4", 32'(grant), 'h2);
        check("s4_last_b4",     32'(m_tlast), 'h1);
        tick(); s_tvalid = 4'b0100; s_tlast = 4'b0100;
        #1 check("s4_grant_moved", 32'(grant), 'h4);
        check("s4_data_src2",      32'(m_tdata), 'hD1);
        check("s4_pkt_cnt7",       32'(pkt_cnt), 'h7);
        check("s4_busy_b2b",       32'(busy),    'h1);
        tick(); s_tvalid = '0; s_tlast = '0;
        #1 check("s4_pkt_cnt8", 32'(pkt_cnt), 'h8);
        check("s4_idle",        32'(busy),    'h0);

        // reset in the middle of source 3's packet
        s_tvalid = 4'b1000; d[3] = 8'hE1;
        tick();
        check("s5_grant", 32'(grant),   'h8);
        check("s5_data",  32'(m_tdata), 'hE1);
        tick(); d[3] = 8'hE2; rst = 1'b1;
        #1 check("s5_data_b2", 32'(m_tdata), 'hE2);
        tick(); rst = 1'b0; s_tvalid = 4'b1001; d[0] = 8'hF0; s_tlast = 4'b0001;
        #1 check("s5_rst_grant", 32'(grant),    'h0);
        check("s5_rst_valid",    32'(m_tvalid), 'h0);
        check("s5_rst_ready",    32'(s_tready), 'h0);
        check("s5_rst_cnt",      32'(pkt_cnt),  'h0);
        tick();
        check("s5_src0_first", 32'(grant),   'h1);
        check("s5_src0_data",  32'(m_tdata), 'hF0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream slave path between NUM_SRC AXI-Stream sources. It sits upstream of the stream slave in the master/slave datapath and decides which source owns the link. Once a source is granted, it keeps the grant until its tlast beat completes, so packets are never interleaved. A completed-packet counter is provided for bench and debug visibility.

## Interface
- NUM_SRC, 4: number of requesting sources, 2..8
- DATA_W, 8: tdata width in bits
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- s_tvalid  in  NUM_SRC  per-source valid
- s_tdata  in  NUM_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W]
- s_tlast  in  NUM_SRC  per-source end of packet
- s_tready  out  NUM_SRC  per-source ready
- m_tvalid  out  1  shared output valid
- m_tdata  out  DATA_W  shared output data
- m_tlast  out  1  shared output end of packet
- m_tready  in  1  downstream ready
- grant  out  NUM_SRC  one-hot current owner; all zeros when no source owns the link
- busy  out  1  high while a packet is in progress (state XFER)
- pkt_cnt  out  16  number of completed packets; wraps from 0xFFFF to 0

## Operation
- States:
  - IDLE: no owner.
  - XFER: one owner, held in register g.
- Arbitration scans sources in round-robin order g_last+1, g_last+2, … modulo NUM_SRC. The first source with s_tvalid=1 wins.
- IDLE:
  - If any s_tvalid is high, the winner is registered into g, grant is set, and the next state is XFER.
  - Otherwise the block stays in IDLE.
- XFER, without the macro:
  - m_tvalid = s_tvalid[g]
  - m_tdata = s_tdata[g]
  - m_tlast = s_tlast[g]
  - s_tready[g] = m_tready
  - s_tready of every non-owner is 0.
- Beat handshake = s_tvalid[g] & s_tready[g].
- Last-beat handshake (handshake with s_tlast[g]=1):
  - pkt_cnt increments by 1.
  - g_last is set to g.
  - Same-cycle re-arbitration runs over sources other than g. If one is valid, the grant moves to it next cycle and the state stays XFER (back-to-back, no idle cycle). Otherwise the next state is IDLE.
- No preemption. A new request never changes the grant before the owner's tlast.
- When the link has no owner: m_tvalid, m_tlast and m_tdata are 0, and s_tready is all zeros.
- Reset values:
  - state IDLE
  - grant 0
  - busy 0
  - m_tvalid 0, m_tlast 0, m_tdata 0
  - s_tready 0
  - pkt_cnt 0
  - g_last = NUM_SRC-1, so source 0 has first priority.
- Reset mid-packet abandons the packet. Sources must restart it.
- An owner deasserting s_tvalid mid-packet keeps the grant (bubble only).

## Timing
- Request to grant: 1 cycle. s_tvalid rises in cycle n, grant and busy are high in n+1, and the first beat can transfer in n+1.
- Without the macro, the data path is combinational from owner to m_*, with zero added latency.
- Throughput: 1 beat/cycle, including across packet boundaries between different sources.
- A source that just finished and is the only requester sees 1 IDLE cycle before it is regranted.
- m_tdata and m_tlast are stable while m_tvalid=1 and m_tready=0, provided the source obeys AXI-Stream rules.

## Configuration
- AXIS_ARB_REGOUT_EN defined:
  - A 2-entry register FIFO is inserted between the selected source and m_*.
  - s_tready[g] = (fifo count < 2).
  - m_* are driven from the FIFO head and registered.
  - Latency is +1 cycle from source handshake to m_tvalid. Full throughput is kept.
  - Grant release and pkt_cnt update on the source-side last handshake.
  - rst empties the FIFO.
- AXIS_ARB_REGOUT_EN undefined: combinational path exactly as in Operation.

## Test plan
- Single 3-beat packet:
  - Stimulus: source 0 only; 3 beats 0x11/0x22/0x33, tlast on 0x33; m_tready=1.
  - Response: grant=0001 one cycle after valid; m_tdata 11,22,33 on consecutive cycles; m_tlast on 33; pkt_cnt=1; busy low afterwards.
- Simultaneous requests:
  - Stimulus: all 4 sources valid right after reset with 1-beat packets 0xA0..0xA3, each re-requesting.
  - Response: grant order 0,1,2,3,0; one beat per cycle with no idle cycles; pkt_cnt=5 after 5 beats.
- Backpressure:
  - Stimulus: m_tready=0 for 3 cycles mid-packet on source 1.
  - Response: s_tready[1]=0; m_tdata holds; no pkt_cnt change; transfer resumes on m_tready=1.
- No preemption:
  - Stimulus: source 2 asserts valid while source 1 is at beat 2 of 4.
  - Response: grant stays 0010 until source 1's tlast handshake, then becomes 0100 the next cycle.
- Reset mid-packet:
  - Stimulus: rst=1 for 1 cycle during source 3's packet.
  - Response: next cycle grant=0, m_tvalid=0, s_tready=0, pkt_cnt=0; the next arbitration favours source 0.
- AXIS_ARB_REGOUT_EN:
  - Stimulus: the simultaneous-requests scenario with the macro defined.
  - Response: identical m_tdata sequence shifted by 1 cycle; still 1 beat/cycle.
